// File: rtl/sdp_ram_init.sv
// sdp_ram_init: simple dual-port RAM (one write port, one read port) with
// byte-lane write enables and a self-clearing sweep after reset.
// After rst falls, every word is written with INIT_VAL, one address per cycle.
// User requests are ignored while the sweep runs.
// Optional build macro SDP_RAM_OUTREG_EN adds a second output register,
// which raises the read latency to 2.

// One write lane: storage for LW bits of every word, plus that lane's read mux.
module sdp_ram_init_lane #(
   parameter int LW       = 8,
   parameter int addrsize = 8,
   parameter int RDW_MODE = 0
) (
   input  logic                clk,
   input  logic                we,
   input  logic [addrsize-1:0] wa,
   input  logic [LW-1:0]       wd,
   input  logic [addrsize-1:0] ra,
   output logic [LW-1:0]       rdat
);
   localparam int DEPTH = 1 << addrsize;

   logic [LW-1:0] mem [DEPTH];

   // lane storage write
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // mode 1 forwards this lane's incoming write on an address match; mode 0 sees pre-write data
   assign rdat = (RDW_MODE == 1 && we && wa == ra) ? wd : mem[ra];
endmodule

module sdp_ram_init #(
   parameter int             MSB      = 8,
   parameter int             addrsize = 8,
   parameter int             NBE      = 1,
   parameter int             RDW_MODE = 0,
   parameter logic [MSB-1:0] INIT_VAL = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [addrsize-1:0] wa,
   input  logic [MSB-1:0]      wd,
   input  logic [NBE-1:0]      wbe,
   input  logic                re,
   input  logic [addrsize-1:0] ra,
   output logic [MSB-1:0]      rd,
   output logic                rd_valid,
   output logic                init_busy
);
   localparam int LW = MSB / NBE;

   typedef enum logic {INIT, RUN} state_t;

   state_t                   state_q, state_d;
   logic [addrsize-1:0]      cnt_q, cnt_d;
   logic                     mem_we;
   logic [addrsize-1:0]      mem_wa;
   logic [NBE-1:0][LW-1:0]   mem_wd;
   logic [NBE-1:0]           mem_be;
   logic                     rd_load;
   logic [NBE-1:0][LW-1:0]   wd_l;
   logic [NBE-1:0][LW-1:0]   rdat;
   logic [MSB-1:0]           rd1;
   logic                     rv1;

   assign wd_l      = wd;
   assign init_busy = rst | (state_q == INIT);

   // state and clear-counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state and the array write port mux: the sweep owns the port in INIT
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      mem_wa  = wa;
      mem_wd  = wd_l;
      mem_be  = wbe;
      rd_load = 1'b0;
      case (state_q)
         INIT: begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = INIT_VAL;
            mem_be = '1;
            cnt_d  = cnt_q + 1'b1;   // addrsize-bit counter wraps naturally
            if (&cnt_q) state_d = RUN;
         end
         RUN: begin
            mem_we  = we;
            rd_load = re;
         end
         default: state_d = INIT;
      endcase
      // no array writes or reads while reset is held
      if (rst) begin
         mem_we  = 1'b0;
         rd_load = 1'b0;
      end
   end

   for (genvar i = 0; i < NBE; i++) begin : g_lane
      sdp_ram_init_lane #(
         .LW       (LW),
         .addrsize (addrsize),
         .RDW_MODE (RDW_MODE)
      ) u_lane (
         .clk  (clk),
         .we   (mem_we & mem_be[i]),
         .wa   (mem_wa),
         .wd   (mem_wd[i]),
         .ra   (ra),
         .rdat (rdat[i])
      );
   end

   // registered read data; rd holds when no read is issued
   always_ff @(posedge clk) begin
      if (rst) begin
         rd1 <= '0;
         rv1 <= 1'b0;
      end else begin
         rv1 <= rd_load;
         if (rd_load) rd1 <= rdat;
      end
   end

`ifdef SDP_RAM_OUTREG_EN
   logic [MSB-1:0] rd2;
   logic           rv2;

   // extra output stage, cleared while reset is held or the sweep runs
   always_ff @(posedge clk) begin
      if (rst || state_q == INIT) begin
         rd2 <= '0;
         rv2 <= 1'b0;
      end else begin
         rd2 <= rd1;
         rv2 <= rv1;
      end
   end

   assign rd       = rd2;
   assign rd_valid = rv2;
`else
   assign rd       = rd1;
   assign rd_valid = rv1;
`endif
endmodule

// File: tb/tb_sdp_ram_init.sv
// Directed bench for sdp_ram_init: two instances (RDW_MODE 0 and 1) share one stimulus.
module tb_sdp_ram_init;
`ifdef SDP_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, we, re;
   logic [3:0]  wa, ra;
   logic [15:0] wd;
   logic [1:0]  wbe;
   logic [15:0] rd0, rd1;
   logic        rv0, rv1, busy0, busy1;

   int total = 0;
   int pass  = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sdp_ram_init #(.MSB(16), .addrsize(4), .NBE(2), .RDW_MODE(0), .INIT_VAL(16'h0000)) dut0 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
      .re(re), .ra(ra), .rd(rd0), .rd_valid(rv0), .init_busy(busy0));

   sdp_ram_init #(.MSB(16), .addrsize(4), .NBE(2), .RDW_MODE(1), .INIT_VAL(16'h0000)) dut1 (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
      .re(re), .ra(ra), .rd(rd1), .rd_valid(rv1), .init_busy(busy1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) pass++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // count busy cycles of a sweep (bounded) and confirm no read completes meanwhile
   task automatic sweep(input string tag);
      int   n;
      logic bad;
      n   = 0;
      bad = 1'b0;
      while (busy0 && n < 100) begin
         tick();
         n++;
         if (rv0 || rv1) bad = 1'b1;
      end
      chk({tag, ".cycles"}, 16'(n), 16'd16);
      chk({tag, ".no_valid"}, {15'd0, bad}, 16'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      we = 1'b1; wa = a; wd = d; wbe = be;
      tick();
      we = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [3:0] a,
                        input logic [15:0] e0, input logic [15:0] e1);
      re = 1'b1; ra = a;
      tick();
      re = 1'b0;
      repeat (LAT - 1) tick();
      chk({tag, ".valid"}, {15'd0, rv0}, 16'd1);
      chk({tag, ".rd0"}, rd0, e0);
      chk({tag, ".rd1"}, rd1, e1);
   endtask

   // simultaneous write and read in one cycle
   task automatic rw(input string tag, input logic [3:0] a_w, input logic [15:0] d,
                     input logic [1:0] be, input logic [3:0] a_r,
                     input logic [15:0] e0, input logic [15:0] e1);
      we = 1'b1; wa = a_w; wd = d; wbe = be;
      re = 1'b1; ra = a_r;
      tick();
      we = 1'b0; re = 1'b0;
      repeat (LAT - 1) tick();
      chk({tag, ".rd0"}, rd0, e0);
      chk({tag, ".rd1"}, rd1, e1);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; wbe = '0;
      repeat (2) tick();
      chk("reset.rd", rd0, 16'h0000);
      chk("reset.valid", {15'd0, rv0}, 16'd0);
      chk("reset.busy", {15'd0, busy0}, 16'd1);

      // first sweep with user requests active: they must be ignored
      rst = 1'b0;
      we = 1'b1; re = 1'b1; wa = 4'd0; ra = 4'd0; wd = 16'hFFFF; wbe = 2'b11;
      sweep("sweep1");
      we = 1'b0; re = 1'b0;
      chk("sweep1.busy1", {15'd0, busy1}, 16'd0);

      for (int a = 0; a < 16; a++) rdchk($sformatf("clr%0d", a), 4'(a), 16'h0000, 16'h0000);

      // lane-masked writes
      wr(4'd5, 16'hA5C3, 2'b11);
      wr(4'd5, 16'hFF00, 2'b10);
      rdchk("merge_hi", 4'd5, 16'hFFC3, 16'hFFC3);
      tick();
      chk("hold.valid", {15'd0, rv0}, 16'd0);
      chk("hold.rd", rd0, 16'hFFC3);
      wr(4'd6, 16'h1234, 2'b11);
      wr(4'd6, 16'hABCD, 2'b01);
      rdchk("merge_lo", 4'd6, 16'h12CD, 16'h12CD);
      wr(4'd6, 16'h0000, 2'b00);
      rdchk("be_none", 4'd6, 16'h12CD, 16'h12CD);

      // read-during-write, same address
      wr(4'd3, 16'h1111, 2'b11);
      rw("rdw_full", 4'd3, 16'h2222, 2'b11, 4'd3, 16'h1111, 16'h2222);
      rdchk("rdw_after", 4'd3, 16'h2222, 16'h2222);
      rw("rdw_lane", 4'd3, 16'h99AA, 2'b01, 4'd3, 16'h2222, 16'h22AA);
      rdchk("rdw_lane_after", 4'd3, 16'h22AA, 16'h22AA);

      // independent read and write at different addresses
      rw("indep", 4'd7, 16'h7777, 2'b11, 4'd5, 16'hFFC3, 16'hFFC3);
      rdchk("indep_after", 4'd7, 16'h7777, 16'h7777);

      // address 15 round trip, then reset during RUN re-clears it
      wr(4'd15, 16'hBEEF, 2'b11);
      rdchk("beef", 4'd15, 16'hBEEF, 16'hBEEF);
      rst = 1'b1;
      tick();
      chk("rst_run.rd", rd0, 16'h0000);
      chk("rst_run.valid", {15'd0, rv0}, 16'd0);
      chk("rst_run.busy", {15'd0, busy0}, 16'd1);
      rst = 1'b0;
      sweep("sweep2");
      rdchk("beef_cleared", 4'd15, 16'h0000, 16'h0000);
      rdchk("five_cleared", 4'd5, 16'h0000, 16'h0000);

      // reset mid-sweep at cnt=7 restarts a full sweep
      wr(4'd9, 16'h5A5A, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (7) tick();
      chk("mid.busy", {15'd0, busy0}, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sweep("sweep3");
      rdchk("nine_cleared", 4'd9, 16'h0000, 16'h0000);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
